// File: rtl/kaipokrandt_controller.sv
// kaipokrandt_controller
// Fetch/decode/execute sequencer for the microcontroller. It holds the 6-bit
// program counter, issues program/data memory requests, strobes the
// instruction register and drives register-file, ALU and bus-select controls
// from the decoded instruction fields.
//
// Ports:
//   clk        in   system clock, rising-edge
//   reset      in   asynchronous active-high reset
//   opcode     in   [3:0] decoded opcode from the instruction register
//   param1     in   [5:0] destination register / first operand
//   param2     in   [5:0] source register / memory address / jump target
//   mem_ready  in   memory handshake (read data valid or write accepted)
//   alu_zero   in   ALU result-is-zero, sampled in EXEC
//   ir_load    out  instruction register capture strobe
//   pc         out  [5:0] program counter
//   mem_addr   out  [5:0] memory address
//   mem_rd     out  memory read request
//   mem_wr     out  memory write request
//   bus_sel    out  [1:0] bus source: 0 mem, 1 ALU, 2 regfile, 3 none
//   alu_op     out  [3:0] ALU function (opcode during EXEC of ALU ops)
//   reg_wr     out  register-file write enable
//   reg_waddr  out  [5:0] register write index (param1)
//   halted     out  high in HALT or FAULT
//   fault      out  high in FAULT
//
// State  | meaning
// FETCH  | read program memory at pc, load IR on mem_ready
// DECODE | IR fields settle, choose MEM / EXEC / HALT
// MEM    | data memory access for LOAD / STORE
// EXEC   | one-cycle ALU / MOVE / jump execution
// HALT   | terminal after HALT instruction
// FAULT  | terminal after memory timeout

module kaipokrandt_controller #(
    parameter logic [5:0] PC_RESET    = 6'd0,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [5:0] param1,
    input  logic [5:0] param2,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output logic       ir_load,
    output logic [5:0] pc,
    output logic [5:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] bus_sel,
    output logic [3:0] alu_op,
    output logic       reg_wr,
    output logic [5:0] reg_waddr,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_MOVE  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_XOR   = 4'h8;
    localparam logic [3:0] OP_NOT   = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] BUS_MEM  = 2'd0;
    localparam logic [1:0] BUS_ALU  = 2'd1;
    localparam logic [1:0] BUS_REG  = 2'd2;
    localparam logic [1:0] BUS_NONE = 2'd3;

    // The wait counter holds the number of wait cycles already spent in the
    // current memory state, so a low mem_ready seen while it equals
    // MEM_TIMEOUT-1 is the final permitted wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [5:0] pc_next;
    logic       zero_flag;
    logic       zero_flag_next;
    logic [7:0] wait_cnt;
    logic       wait_expired;

    assign reg_waddr    = param1;
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= PC_RESET;
            zero_flag <= 1'b0;
            wait_cnt  <= 8'd0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            zero_flag <= zero_flag_next;
            if (state_next != state) begin
                wait_cnt <= 8'd0;
            end else if ((state == S_FETCH || state == S_MEM) && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        zero_flag_next = zero_flag;
        ir_load        = 1'b0;
        mem_addr       = 6'd0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        bus_sel        = BUS_NONE;
        alu_op         = 4'd0;
        reg_wr         = 1'b0;
        halted         = 1'b0;
        fault          = 1'b0;

        // Outputs are decoded from state; gating with reset keeps every
        // strobe idle for the whole time reset is held, not only after it.
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_addr = pc;
                    mem_rd   = 1'b1;
                    bus_sel  = BUS_MEM;
                    if (mem_ready) begin
                        ir_load    = 1'b1;
                        pc_next    = pc + 6'd1;
                        state_next = S_DECODE;
                    end else if (wait_expired) begin
                        state_next = S_FAULT;
                    end
                end

                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = S_MEM;
                        OP_HALT:           state_next = S_HALT;
                        default:           state_next = S_EXEC;
                    endcase
                end

                S_MEM: begin
                    mem_addr = param2;
                    if (opcode == OP_STORE) begin
                        mem_wr  = 1'b1;
                        bus_sel = BUS_REG;
                    end else begin
                        mem_rd  = 1'b1;
                        bus_sel = BUS_MEM;
                    end
                    if (mem_ready) begin
                        reg_wr     = (opcode == OP_LOAD);
                        state_next = S_FETCH;
                    end else if (wait_expired) begin
                        state_next = S_FAULT;
                    end
                end

                S_EXEC: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                            alu_op         = opcode;
                            bus_sel        = BUS_ALU;
                            reg_wr         = 1'b1;
                            zero_flag_next = alu_zero;
                        end
                        OP_MOVE: begin
                            bus_sel = BUS_REG;
                            reg_wr  = 1'b1;
                        end
                        OP_JMP: pc_next = param2;
                        OP_JZ: begin
                            if (zero_flag) begin
                                pc_next = param2;
                            end
                        end
                        default: ;
                    endcase
                    state_next = S_FETCH;
                end

                S_HALT: begin
                    halted = 1'b1;
                end

                S_FAULT: begin
                    halted = 1'b1;
                    fault  = 1'b1;
                end

                default: state_next = S_FAULT;
            endcase
        end
    end

endmodule
